// File: rtl/sram_100_qsys_cpu_div_cell.sv
// Iterative 32/32 restoring divider for the CPU execute stage (DIV/DIVU).
// One quotient bit per clock; signed mode divides magnitudes, then fixes signs.
// Optional build macro: DIV_ZERO_EARLY_OUT_EN (zero divisor skips the iterations
// and raises A_div_by_zero; otherwise A_div_by_zero is tied low).
module sram_100_qsys_cpu_div_cell #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_div_start,
    input  logic              A_div_signed,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    output logic              A_div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_quotient,
    output logic [DATA_W-1:0] A_div_remainder,
    output logic              A_div_by_zero
);

    localparam int MSB = DATA_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic              r_signed;
    logic [DATA_W-1:0] r_rem;     // partial remainder accumulator
    logic [DATA_W-1:0] r_dvd;     // dividend shifts out, quotient bits shift in
    logic [DATA_W-1:0] r_dsr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_remo;

    logic              w_neg1;
    logic              w_neg2;
    logic              w_src2_zero;
    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;
    logic [DATA_W+1:0] w_trial;
    logic              w_trial_neg;
    logic [DATA_W-1:0] w_quo_fix;
    logic [DATA_W-1:0] w_rem_fix;

    // Operand signs only matter in signed mode; magnitudes are treated as unsigned
    // so the most negative value maps onto itself.
    assign w_neg1      = r_signed & r_src1[MSB];
    assign w_neg2      = r_signed & r_src2[MSB];
    assign w_src2_zero = (r_src2 == '0);
    assign w_abs1      = w_neg1 ? ({DATA_W{1'b0}} - r_src1) : r_src1;
    assign w_abs2      = w_neg2 ? ({DATA_W{1'b0}} - r_src2) : r_src2;

    // The shifted remainder can need DATA_W+1 bits when the divisor exceeds
    // 2**(DATA_W-1), so the subtraction carries one extra bit for its sign.
    assign w_trial     = {1'b0, r_rem, r_dvd[MSB]} - {2'b00, r_dsr};
    assign w_trial_neg = w_trial[DATA_W+1];

    // Final sign correction, with the fixed divide-by-zero result taking priority.
    always_comb begin
        w_quo_fix = r_dvd;
        w_rem_fix = r_rem;
        if (w_src2_zero) begin
            w_quo_fix = '1;
            w_rem_fix = r_src1;
        end else begin
            if (w_neg1 ^ w_neg2) begin
                w_quo_fix = {DATA_W{1'b0}} - r_dvd;
            end
            if (w_neg1) begin
                w_rem_fix = {DATA_W{1'b0}} - r_rem;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (A_div_start) begin
                    w_state_next = S_PREP;
                end
            end
            S_PREP: begin
`ifdef DIV_ZERO_EARLY_OUT_EN
                w_state_next = w_src2_zero ? S_FIX : S_ITER;
`else
                w_state_next = S_ITER;
`endif
            end
            S_ITER: begin
                if (r_cnt == {CNT_W{1'b1}}) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands, iterate the restoring step, register results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src1   <= '0;
            r_src2   <= '0;
            r_signed <= 1'b0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_remo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (A_div_start) begin
                        r_src1   <= A_div_src1;
                        r_src2   <= A_div_src2;
                        r_signed <= A_div_signed;
                    end
                end
                S_PREP: begin
                    r_rem <= '0;
                    r_dvd <= w_abs1;
                    r_dsr <= w_abs2;
                    r_cnt <= '0;
                end
                S_ITER: begin
                    if (w_trial_neg) begin
                        r_rem <= {r_rem[DATA_W-2:0], r_dvd[MSB]};
                    end else begin
                        r_rem <= w_trial[DATA_W-1:0];
                    end
                    r_dvd <= {r_dvd[DATA_W-2:0], ~w_trial_neg};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_quo  <= w_quo_fix;
                    r_remo <= w_rem_fix;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_EARLY_OUT_EN
    logic r_by_zero;

    // Divide-by-zero flag travels with the results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_by_zero <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_by_zero <= w_src2_zero;
        end
    end

    assign A_div_by_zero = r_by_zero;
`else
    assign A_div_by_zero = 1'b0;
`endif

    assign A_div_busy      = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
    assign A_div_done      = (r_state == S_DONE);
    assign A_div_quotient  = r_quo;
    assign A_div_remainder = r_remo;

endmodule

// File: tb/tb_sram_100_qsys_cpu_div_cell.sv
// Directed bench for the iterative divider: a cycle-level behavioural model
// (arithmetic results plus start/latency bookkeeping) is compared against the
// DUT on every cycle, and each transaction also checks hand-computed literals.
module tb_sram_100_qsys_cpu_div_cell;

`ifdef DIV_ZERO_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        A_div_start;
    logic        A_div_signed;
    logic [31:0] A_div_src1;
    logic [31:0] A_div_src2;
    logic        A_div_busy;
    logic        A_div_done;
    logic [31:0] A_div_quotient;
    logic [31:0] A_div_remainder;
    logic        A_div_by_zero;

    int checks = 0;
    int errors = 0;

    sram_100_qsys_cpu_div_cell #(.DATA_W(32), .CNT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .A_div_start     (A_div_start),
        .A_div_signed    (A_div_signed),
        .A_div_src1      (A_div_src1),
        .A_div_src2      (A_div_src2),
        .A_div_busy      (A_div_busy),
        .A_div_done      (A_div_done),
        .A_div_quotient  (A_div_quotient),
        .A_div_remainder (A_div_remainder),
        .A_div_by_zero   (A_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the division rules.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint tq;
        longint tr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0];
            r  = tr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_en = 0;
    bit          m_active = 0;
    int          m_start = 0;
    int          m_lat = 35;
    logic [31:0] m_exp_q = '0;
    logic [31:0] m_exp_r = '0;
    logic        m_exp_z = 1'b0;
    logic [31:0] m_q_out = '0;
    logic [31:0] m_r_out = '0;
    logic        m_z_out = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_en     = 1;
            m_active = 0;
            m_q_out  = '0;
            m_r_out  = '0;
            m_z_out  = 1'b0;
        end else if (A_div_start && !m_active) begin
            m_active = 1;
            m_start  = cyc;
            ref_div(A_div_src1, A_div_src2, A_div_signed, m_exp_q, m_exp_r);
            m_exp_z  = EARLY && (A_div_src2 == 32'd0);
            m_lat    = (EARLY && (A_div_src2 == 32'd0)) ? 3 : 35;
        end else if (m_active && cyc == m_start + m_lat) begin
            m_active = 0;
        end
        cyc++;
        if (m_active && cyc == m_start + m_lat) begin
            m_q_out = m_exp_q;
            m_r_out = m_exp_r;
            m_z_out = m_exp_z;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_en) begin
            check("busy", {31'd0, A_div_busy},
                  {31'd0, m_active && cyc > m_start && cyc < m_start + m_lat});
            check("done", {31'd0, A_div_done}, {31'd0, m_active && cyc == m_start + m_lat});
            check("quotient", A_div_quotient, m_q_out);
            check("remainder", A_div_remainder, m_r_out);
            check("by_zero", {31'd0, A_div_by_zero}, {31'd0, m_z_out});
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input logic [31:0] s1, input logic [31:0] s2, input logic sg);
        A_div_start  = 1'b1;
        A_div_src1   = s1;
        A_div_src2   = s2;
        A_div_signed = sg;
        @(posedge clk);
        #1;
        A_div_start  = 1'b0;
    endtask

    // Waits (bounded) for done; reports its cycle and busy-cycle count.
    task automatic wait_done(output int dc, output int nbusy);
        bit found;
        found = 0;
        nbusy = 0;
        dc    = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (A_div_busy) nbusy++;
            if (A_div_done) begin
                found = 1;
                dc    = cyc;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] s1, input logic [31:0] s2,
                          input logic sg, input logic [31:0] eq, input logic [31:0] er,
                          input int elat);
        int t0;
        int dc;
        int nb;
        t0 = cyc;
        pulse_start(s1, s2, sg);
        wait_done(dc, nb);
        check({name, "_lat"}, dc - t0, elat);
        check({name, "_busy_cycles"}, nb, elat - 1);
        check({name, "_q"}, A_div_quotient, eq);
        check({name, "_r"}, A_div_remainder, er);
        check({name, "_model_q"}, m_exp_q, eq);
        check({name, "_model_r"}, m_exp_r, er);
        check({name, "_byz"}, {31'd0, A_div_by_zero}, {31'd0, EARLY && (s2 == 32'd0)});
        $display("txn %s: src1=%h src2=%h signed=%0d -> q=%h r=%h byz=%0d lat=%0d",
                 name, s1, s2, sg, A_div_quotient, A_div_remainder, A_div_by_zero, dc - t0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int dc;
        int nb;
        int ndone;
        reset        = 1'b1;
        A_div_start  = 1'b0;
        A_div_signed = 1'b0;
        A_div_src1   = '0;
        A_div_src2   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, A_div_busy}, 32'd0);
        check("rst_done", {31'd0, A_div_done}, 32'd0);
        check("rst_q", A_div_quotient, 32'd0);
        check("rst_r", A_div_remainder, 32'd0);
        check("rst_byz", {31'd0, A_div_by_zero}, 32'd0);
        @(posedge clk);
        #1;

        run_op("udiv",    32'd100,       32'd7,         1'b0, 32'd14,        32'd2,        35);
        run_op("sdiv_nd", 32'hFFFFFF9C, 32'd7,         1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 35);
        run_op("sdiv_nv", 32'd100,       32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        35);
        run_op("sovf",    32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        35);
        run_op("umax",    32'hFFFFFFFF, 32'd1,         1'b0, 32'hFFFFFFFF, 32'd0,        35);
        run_op("ubigdsr", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32'd1,         32'd1,        35);
        run_op("umsb3",   32'h80000000, 32'd3,         1'b0, 32'h2AAAAAAA, 32'd2,        35);
        run_op("sneg2",   32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,         32'hFFFFFFFF, 35);
        run_op("udz",     32'h12345678, 32'd0,         1'b0, 32'hFFFFFFFF, 32'h12345678, EARLY ? 3 : 35);
        run_op("sdz",     32'h80000001, 32'd0,         1'b1, 32'hFFFFFFFF, 32'h80000001, EARLY ? 3 : 35);

        // Start during busy and in the done cycle are ignored; T+36 is accepted.
        t0 = cyc;
        pulse_start(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        pulse_start(32'd999, 32'd3, 1'b0);
        wait_done(dc, nb);
        check("hs_lat", dc - t0, 32'd35);
        check("hs_q", A_div_quotient, 32'd14);
        check("hs_r", A_div_remainder, 32'd2);
        A_div_start = 1'b1;
        A_div_src1  = 32'd50;
        A_div_src2  = 32'd5;
        @(posedge clk);
        #1;
        A_div_start = 1'b0;
        check("hs_done_start_ignored", {31'd0, A_div_busy}, 32'd0);
        check("hs_hold_q", A_div_quotient, 32'd14);
        $display("txn handshake: first result q=%h r=%h kept", A_div_quotient, A_div_remainder);
        run_op("hs_next", 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 35);

        // Reset mid-operation discards the operation with no done pulse.
        pulse_start(32'd12345, 32'd10, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rstmid_busy", {31'd0, A_div_busy}, 32'd0);
        check("rstmid_q", A_div_quotient, 32'd0);
        check("rstmid_r", A_div_remainder, 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (A_div_done) ndone++;
        end
        check("rstmid_no_done", ndone, 32'd0);
        $display("txn reset_mid: busy=%0d q=%h done_pulses=%0d", A_div_busy, A_div_quotient, ndone);

        // Start in the same cycle as reset is ignored.
        @(posedge clk);
        #1;
        reset       = 1'b1;
        A_div_start = 1'b1;
        A_div_src1  = 32'd77;
        A_div_src2  = 32'd7;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        A_div_start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", {31'd0, A_div_busy}, 32'd0);
        $display("txn reset_with_start: busy=%0d", A_div_busy);
        @(posedge clk);
        #1;
        run_op("after_rst", 32'd12345, 32'd10, 1'b0, 32'd1234, 32'd5, 35);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
